// File: rtl/uart_cmd_rcv.sv
// UART 8N1 receiver that pairs two bytes (high first) into a 16-bit command word.
// Flags a bad stop bit or an overlong gap between the two bytes with a one-cycle frm_err.
module uart_cmd_rcv #(
   parameter int BAUD_DIV = 2604,
   parameter int GAP_BITS = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RX,
   input  logic        clr_cmd_rdy,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   output logic        frm_err
);

   localparam int CW      = $clog2(BAUD_DIV);
   localparam int GAP_LIM = GAP_BITS * BAUD_DIV;
   localparam int GW      = $clog2(GAP_LIM + 1);

   localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);
   localparam logic [GW-1:0] GAP_M1  = GW'(GAP_LIM - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   localparam logic [0:0] WAIT_HI = 1'b0;
   localparam logic [0:0] WAIT_LO = 1'b1;

   logic          rx_ff1, rx_s, rx_prev;
   logic [1:0]    state;
   logic [CW-1:0] baud_cnt;
   logic [3:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          byte_vld;
   logic [0:0]    asm_st;
   logic [7:0]    hi_byte;
   logic [GW-1:0] gap_cnt;

   logic start_det, start_smp, data_smp, stop_smp, gap_to;

   always_comb begin
      start_det = (state == IDLE) && rx_prev && !rx_s;
      start_smp = (state == START) && (baud_cnt == HALF_M1);
      data_smp  = (state == DATA)  && (baud_cnt == FULL_M1);
      stop_smp  = (state == STOP)  && (baud_cnt == FULL_M1);
      gap_to    = (asm_st == WAIT_LO) && (state == IDLE) && (gap_cnt == GAP_M1);
   end

   // Bit-level receiver; rx_prev tracks rx_s in every state so only IDLE can see a start edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_ff1   <= 1'b1;
         rx_s     <= 1'b1;
         rx_prev  <= 1'b1;
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         byte_vld <= 1'b0;
      end else begin
         rx_ff1   <= RX;
         rx_s     <= rx_ff1;
         rx_prev  <= rx_s;
         byte_vld <= 1'b0;
         case (state)
            IDLE: begin
               if (start_det) begin
                  state    <= START;
                  baud_cnt <= '0;
               end
            end
            START: begin
               if (start_smp) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  state    <= rx_s ? IDLE : DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (data_smp) begin
                  baud_cnt <= '0;
                  shreg    <= {rx_s, shreg[7:1]};
                  bit_cnt  <= bit_cnt + 1'b1;
                  if (bit_cnt == 4'd7) state <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               if (stop_smp) begin
                  baud_cnt <= '0;
                  state    <= IDLE;
                  byte_vld <= rx_s;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   // Byte pair assembler; shreg is stable during the byte_vld cycle because the bit FSM is IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         asm_st  <= WAIT_HI;
         hi_byte <= '0;
         gap_cnt <= '0;
         cmd     <= '0;
         cmd_rdy <= 1'b0;
         frm_err <= 1'b0;
      end else begin
         frm_err <= 1'b0;
         if (stop_smp && !rx_s) begin
            frm_err <= 1'b1;
            asm_st  <= WAIT_HI;
         end else if (byte_vld) begin
            if (asm_st == WAIT_HI) begin
               hi_byte <= shreg;
               asm_st  <= WAIT_LO;
            end else begin
               cmd    <= {hi_byte, shreg};
               asm_st <= WAIT_HI;
            end
         end else if (gap_to) begin
            frm_err <= 1'b1;
            asm_st  <= WAIT_HI;
         end

         if ((byte_vld && asm_st == WAIT_HI) || start_det)
            gap_cnt <= '0;
         else if (asm_st == WAIT_LO && state == IDLE)
            gap_cnt <= gap_to ? '0 : gap_cnt + 1'b1;

         // A completed pair beats any clear arriving in the same cycle.
         if (byte_vld && asm_st == WAIT_LO)
            cmd_rdy <= 1'b1;
         else if (clr_cmd_rdy || (start_smp && !rx_s && asm_st == WAIT_HI))
            cmd_rdy <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_cmd_rcv.sv
// Directed bench for uart_cmd_rcv: serial byte driver, expected-command queue, negedge monitor.
module tb_uart_cmd_rcv;

   localparam int B   = 16;
   localparam int GB  = 20;
   localparam int LAT = 3 + B / 2 + 9 * B + 1;
   localparam int GAP_EXP = LAT + GB * B;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        RX;
   logic        clr_cmd_rdy;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        frm_err;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int last_start = 0;
   int err_cnt = 0;
   int err_cyc = 0;
   logic [15:0] exp_q[$];
   logic [15:0] prev_cmd = '0;
   logic        prev_rdy = 1'b0;

   uart_cmd_rcv #(.BAUD_DIV(B), .GAP_BITS(GB)) dut (
      .clk(clk), .rst_n(rst_n), .RX(RX), .clr_cmd_rdy(clr_cmd_rdy),
      .cmd(cmd), .cmd_rdy(cmd_rdy), .frm_err(frm_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: a command event is a rising cmd_rdy or a change of cmd outside reset.
   always @(negedge clk) begin
      if (rst_n) begin
         if (frm_err) begin
            err_cnt++;
            err_cyc = cyc;
         end
         if ((cmd_rdy && !prev_rdy) || cmd != prev_cmd) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_cmd", {16'h0, cmd}, 32'hDEAD_0000);
            end else begin
               logic [15:0] e;
               e = exp_q.pop_front();
               chk("cmd_value", {16'h0, cmd}, {16'h0, e});
               chk("cmd_rdy_set", {31'h0, cmd_rdy}, 32'd1);
               chk("cmd_latency", cyc - last_start, LAT);
            end
         end
      end
      prev_cmd = cmd;
      prev_rdy = cmd_rdy;
   end

   task automatic send_byte(input logic [7:0] b, input logic stop);
      @(negedge clk);
      last_start = cyc;
      RX = 1'b0;
      repeat (B) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         RX = b[i];
         repeat (B) @(negedge clk);
      end
      RX = stop;
      repeat (B - 1) @(negedge clk);
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      RX = 1'b1;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic clr_pulse();
      @(negedge clk);
      clr_cmd_rdy = 1'b1;
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
   endtask

   task automatic queue_empty(input string name);
      chk(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      int t_hi;
      RX = 1'b1;
      rst_n = 1'b0;
      clr_cmd_rdy = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_cmd", {16'h0, cmd}, 32'h0);
      chk("reset_rdy", {31'h0, cmd_rdy}, 32'h0);
      chk("reset_err", {31'h0, frm_err}, 32'h0);
      rst_n = 1'b1;
      idle(2 * B);

      // 0x5555 as two 0x55 bytes
      e0 = err_cnt;
      exp_q.push_back(16'h5555);
      send_byte(8'h55, 1'b1);
      send_byte(8'h55, 1'b1);
      idle(B);
      queue_empty("s30_delivered");
      chk("s30_no_err", err_cnt - e0, 0);
      clr_pulse();
      @(negedge clk);
      chk("s30_clr_rdy", {31'h0, cmd_rdy}, 32'h0);
      chk("s30_cmd_hold", {16'h0, cmd}, 32'h5555);

      // 0xFFFF then 0x002D without acknowledging in between
      exp_q.push_back(16'hFFFF);
      send_byte(8'hFF, 1'b1);
      send_byte(8'hFF, 1'b1);
      exp_q.push_back(16'h002D);
      send_byte(8'h00, 1'b1);
      send_byte(8'h2D, 1'b1);
      idle(B);
      queue_empty("s31_delivered");
      chk("s31_rdy", {31'h0, cmd_rdy}, 32'h1);
      chk("s31_cmd", {16'h0, cmd}, 32'h002D);
      clr_pulse();
      @(negedge clk);
      chk("s31_clr_rdy", {31'h0, cmd_rdy}, 32'h0);
      chk("s31_cmd_hold", {16'h0, cmd}, 32'h002D);

      // short low glitch on idle line
      e0 = err_cnt;
      @(negedge clk);
      RX = 1'b0;
      repeat (5) @(negedge clk);
      RX = 1'b1;
      idle(3 * B);
      queue_empty("s32_no_cmd");
      chk("s32_cmd", {16'h0, cmd}, 32'h002D);
      chk("s32_rdy", {31'h0, cmd_rdy}, 32'h0);
      chk("s32_no_err", err_cnt - e0, 0);

      // bad stop bit on the low byte, then a clean pair
      e0 = err_cnt;
      send_byte(8'hAA, 1'b1);
      send_byte(8'h77, 1'b0);
      idle(2 * B);
      chk("s33_one_err", err_cnt - e0, 1);
      chk("s33_rdy", {31'h0, cmd_rdy}, 32'h0);
      chk("s33_cmd_hold", {16'h0, cmd}, 32'h002D);
      exp_q.push_back(16'h001E);
      send_byte(8'h00, 1'b1);
      send_byte(8'h1E, 1'b1);
      idle(B);
      queue_empty("s33_delivered");
      chk("s33_cmd", {16'h0, cmd}, 32'h001E);
      clr_pulse();

      // inter-byte timeout: 0x12, 25 idle bit periods, then 0x34 0x56
      e0 = err_cnt;
      send_byte(8'h12, 1'b1);
      t_hi = last_start;
      idle(25 * B);
      chk("s34_one_err", err_cnt - e0, 1);
      chk("s34_err_time_lo", {31'h0, (err_cyc - t_hi) >= GAP_EXP - 2}, 32'h1);
      chk("s34_err_time_hi", {31'h0, (err_cyc - t_hi) <= GAP_EXP + 2}, 32'h1);
      chk("s34_rdy", {31'h0, cmd_rdy}, 32'h0);
      exp_q.push_back(16'h3456);
      send_byte(8'h34, 1'b1);
      send_byte(8'h56, 1'b1);
      idle(B);
      queue_empty("s34_delivered");
      chk("s34_cmd", {16'h0, cmd}, 32'h3456);
      chk("s34_err_total", err_cnt - e0, 1);

      // reset for 3 clocks during the data bits of a high byte, then 0xAAAA
      fork
         send_byte(8'hFF, 1'b1);
         begin
            repeat (4 * B) @(negedge clk);
            rst_n = 1'b0;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               chk("s35_rst_cmd", {16'h0, cmd}, 32'h0);
               chk("s35_rst_rdy", {31'h0, cmd_rdy}, 32'h0);
               chk("s35_rst_err", {31'h0, frm_err}, 32'h0);
            end
            rst_n = 1'b1;
         end
      join
      idle(2 * B);
      queue_empty("s35_no_cmd");
      exp_q.push_back(16'hAAAA);
      send_byte(8'hAA, 1'b1);
      send_byte(8'hAA, 1'b1);
      idle(B);
      queue_empty("s35_delivered");
      chk("s35_cmd", {16'h0, cmd}, 32'hAAAA);
      chk("s35_rdy", {31'h0, cmd_rdy}, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
